// File: rtl/sdram_arb_pkg.sv
// sdram_arb_pkg: shared state encoding, owner codes and default timing
// constants for the SDRAM arbiter and its refresh timer.
package sdram_arb_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        GNT_Z3  = 3'd1,
        GNT_AUX = 3'd2,
        REFRESH = 3'd3,
        RELEASE = 3'd4
    } arb_state_e;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_Z3   = 2'd1,
        OWN_AUX  = 2'd2,
        OWN_REF  = 2'd3
    } owner_e;

    // 177 cycles at 25 MHz is roughly 7.1 us between refreshes
    localparam int REFRESH_CYCLES_DEF = 177;
    localparam int AUX_MAX_WAIT_DEF   = 16;

    localparam logic [3:0] DS_NONE = 4'b1111;

endpackage

// File: rtl/sdram_refresh_timer.sv
// sdram_refresh_timer: free-running refresh interval timer with a small
// saturating count of refreshes still owed, and a sticky overrun flag
// raised when an interval expires while that count is already full.
module sdram_refresh_timer
    import sdram_arb_pkg::*;
#(
    parameter int REFRESH_CYCLES = REFRESH_CYCLES_DEF,
    parameter int TMR_W          = 8
) (
    input  logic CLK,
    input  logic RESET,
    input  logic ref_done,
    output logic ref_pend_nz,
    output logic ref_overrun
);

    localparam logic [TMR_W-1:0] TMR_RELOAD = TMR_W'(REFRESH_CYCLES - 1);

    logic [TMR_W-1:0] r_tmr;
    logic [1:0]       r_ref_pend;
    logic             w_expire;

    assign w_expire    = (r_tmr == {TMR_W{1'b0}});
    assign ref_pend_nz = (r_ref_pend != 2'd0);

    // Down-counter that reloads on reaching zero; zero marks one interval
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_tmr <= TMR_RELOAD;
        end else if (w_expire) begin
            r_tmr <= TMR_RELOAD;
        end else begin
            r_tmr <= r_tmr - TMR_W'(1);
        end
    end

    // Refreshes owed: +1 per expiry, -1 per completion, net zero when both
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_ref_pend <= 2'd0;
        end else if (w_expire && !ref_done) begin
            if (r_ref_pend != 2'd3) begin
                r_ref_pend <= r_ref_pend + 2'd1;
            end else begin
                r_ref_pend <= r_ref_pend;
            end
        end else if (ref_done && !w_expire) begin
            if (r_ref_pend != 2'd0) begin
                r_ref_pend <= r_ref_pend - 2'd1;
            end else begin
                r_ref_pend <= r_ref_pend;
            end
        end else begin
            r_ref_pend <= r_ref_pend;
        end
    end

    // Sticky overrun: an interval expired with three refreshes already owed
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            ref_overrun <= 1'b0;
        end else if (w_expire && (r_ref_pend == 2'd3)) begin
            ref_overrun <= 1'b1;
        end else begin
            ref_overrun <= ref_overrun;
        end
    end

endmodule

// File: rtl/sdram_arbiter.sv
// sdram_arbiter: shares the SDRAM sequencer between the Zorro III slave
// path (z3) and the auxiliary master (aux), and schedules auto-refresh.
// Priority is refresh > z3 > aux. Build option SDRAM_ARB_STARVE_GUARD_EN
// adds a wait counter that lets aux jump ahead of z3 once it has waited
// AUX_MAX_WAIT cycles; without it aux can starve under constant z3 load.
module sdram_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int REFRESH_CYCLES = REFRESH_CYCLES_DEF,
    parameter int AUX_MAX_WAIT   = AUX_MAX_WAIT_DEF,
    parameter int TMR_W          = 8
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        z3_req,
    input  logic [25:0] z3_addr,
    input  logic [3:0]  z3_ds_n,
    input  logic        z3_rw,
    output logic        z3_ack,
    input  logic        aux_req,
    input  logic [25:0] aux_addr,
    input  logic [3:0]  aux_ds_n,
    input  logic        aux_rw,
    output logic        aux_ack,
    output logic        mem_req,
    output logic [25:0] mem_addr,
    output logic [3:0]  mem_ds_n,
    output logic        mem_rw,
    input  logic        mem_done,
    output logic        ref_req,
    input  logic        ref_done,
    output logic [1:0]  owner,
    output logic        ref_overrun
);

    arb_state_e r_state;
    logic       w_ref_pend_nz;
    logic       w_ref_done_valid;
    logic       w_aux_urgent;

    // A ref_done that arrives outside REFRESH must not retire a refresh
    assign w_ref_done_valid = ref_done && (r_state == REFRESH);

    sdram_refresh_timer #(
        .REFRESH_CYCLES(REFRESH_CYCLES),
        .TMR_W         (TMR_W)
    ) u_refresh_timer (
        .CLK        (CLK),
        .RESET      (RESET),
        .ref_done   (w_ref_done_valid),
        .ref_pend_nz(w_ref_pend_nz),
        .ref_overrun(ref_overrun)
    );

`ifdef SDRAM_ARB_STARVE_GUARD_EN
    localparam int AW = $clog2(AUX_MAX_WAIT + 1);
    localparam logic [AW-1:0] AUX_WAIT_SAT = AW'(AUX_MAX_WAIT);

    logic [AW-1:0] r_aux_wait;

    assign w_aux_urgent = aux_req && (r_aux_wait >= AUX_WAIT_SAT);

    // Count cycles aux spends requesting while it does not own the port
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_aux_wait <= {AW{1'b0}};
        end else if (!aux_req || (owner == OWN_AUX)) begin
            r_aux_wait <= {AW{1'b0}};
        end else if (r_aux_wait < AUX_WAIT_SAT) begin
            r_aux_wait <= r_aux_wait + AW'(1);
        end else begin
            r_aux_wait <= r_aux_wait;
        end
    end
`else
    logic w_unused_aux_max_wait;

    assign w_aux_urgent          = 1'b0;
    assign w_unused_aux_max_wait = (AUX_MAX_WAIT != 0);
`endif

    // Arbitration FSM; every downstream and ack output is a register here
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state  <= IDLE;
            mem_req  <= 1'b0;
            mem_addr <= 26'd0;
            mem_ds_n <= DS_NONE;
            mem_rw   <= 1'b0;
            ref_req  <= 1'b0;
            owner    <= OWN_NONE;
            z3_ack   <= 1'b0;
            aux_ack  <= 1'b0;
        end else begin
            z3_ack  <= 1'b0;
            aux_ack <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_ref_pend_nz) begin
                        r_state <= REFRESH;
                        ref_req <= 1'b1;
                        owner   <= OWN_REF;
                    end else if (w_aux_urgent || (aux_req && !z3_req)) begin
                        r_state  <= GNT_AUX;
                        mem_req  <= 1'b1;
                        mem_addr <= aux_addr;
                        mem_ds_n <= aux_ds_n;
                        mem_rw   <= aux_rw;
                        owner    <= OWN_AUX;
                    end else if (z3_req) begin
                        r_state  <= GNT_Z3;
                        mem_req  <= 1'b1;
                        mem_addr <= z3_addr;
                        mem_ds_n <= z3_ds_n;
                        mem_rw   <= z3_rw;
                        owner    <= OWN_Z3;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                GNT_Z3: begin
                    if (mem_done) begin
                        mem_req <= 1'b0;
                        z3_ack  <= 1'b1;
                        r_state <= RELEASE;
                    end else begin
                        r_state <= GNT_Z3;
                    end
                end
                GNT_AUX: begin
                    if (mem_done) begin
                        mem_req <= 1'b0;
                        aux_ack <= 1'b1;
                        r_state <= RELEASE;
                    end else begin
                        r_state <= GNT_AUX;
                    end
                end
                REFRESH: begin
                    if (ref_done) begin
                        ref_req <= 1'b0;
                        r_state <= RELEASE;
                    end else begin
                        r_state <= REFRESH;
                    end
                end
                RELEASE: begin
                    // Gap cycle lets the acked requester drop its request
                    owner    <= OWN_NONE;
                    mem_ds_n <= DS_NONE;
                    r_state  <= IDLE;
                end
                default: begin
                    r_state  <= IDLE;
                    mem_req  <= 1'b0;
                    ref_req  <= 1'b0;
                    owner    <= OWN_NONE;
                    mem_ds_n <= DS_NONE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter: directed self-checking bench for sdram_arbiter,
// built with a short refresh interval so refresh behaviour is reachable.
module tb_sdram_arbiter;

    localparam int N = 32;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        z3_req, z3_rw, aux_req, aux_rw;
    logic [25:0] z3_addr, aux_addr;
    logic [3:0]  z3_ds_n, aux_ds_n;
    logic        z3_ack, aux_ack;
    logic        mem_req, mem_rw, mem_done;
    logic [25:0] mem_addr;
    logic [3:0]  mem_ds_n;
    logic        ref_req, ref_done, ref_overrun;
    logic [1:0]  owner;

    int checks   = 0;
    int failures = 0;
    bit auto_mem = 1'b0;
    bit auto_ref = 1'b0;
    int mem_cnt  = 0;

    sdram_arbiter #(
        .REFRESH_CYCLES(N),
        .AUX_MAX_WAIT  (16),
        .TMR_W         (8)
    ) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .z3_req     (z3_req),
        .z3_addr    (z3_addr),
        .z3_ds_n    (z3_ds_n),
        .z3_rw      (z3_rw),
        .z3_ack     (z3_ack),
        .aux_req    (aux_req),
        .aux_addr   (aux_addr),
        .aux_ds_n   (aux_ds_n),
        .aux_rw     (aux_rw),
        .aux_ack    (aux_ack),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ds_n   (mem_ds_n),
        .mem_rw     (mem_rw),
        .mem_done   (mem_done),
        .ref_req    (ref_req),
        .ref_done   (ref_done),
        .owner      (owner),
        .ref_overrun(ref_overrun)
    );

    always #5 CLK = ~CLK;

    // One clock; optional sequencer model answers mem_req after 2 cycles
    // and ref_req after 1 cycle
    task automatic step();
        @(posedge CLK);
        #1;
        if (auto_mem) begin
            mem_done = 1'b0;
            if (mem_req) begin
                mem_cnt++;
                if (mem_cnt >= 2) begin
                    mem_done = 1'b1;
                    mem_cnt  = 0;
                end
            end else begin
                mem_cnt = 0;
            end
        end
        if (auto_ref) ref_done = ref_req;
    endtask

    task automatic do_reset();
        RESET    = 1'b1;
        z3_req   = 1'b0; z3_rw  = 1'b0; z3_addr  = 26'd0; z3_ds_n  = 4'b1111;
        aux_req  = 1'b0; aux_rw = 1'b0; aux_addr = 26'd0; aux_ds_n = 4'b1111;
        mem_done = 1'b0; ref_done = 1'b0;
        auto_mem = 1'b0; auto_ref = 1'b0; mem_cnt = 0;
        repeat (2) @(posedge CLK);
        #1;
        RESET = 1'b0;
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        #1;
        checks++;
        if ({mem_req, ref_req, z3_ack, aux_ack, ref_overrun, mem_rw} !== 6'b000000) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=000000",
                     {mem_req, ref_req, z3_ack, aux_ack, ref_overrun, mem_rw});
        end
        checks++;
        if (mem_ds_n !== 4'b1111 || owner !== 2'd0 || mem_addr !== 26'd0) begin
            failures++;
            $display("FAIL reset_values ds_n=%b owner=%0d addr=%h exp ds_n=1111 owner=0 addr=0",
                     mem_ds_n, owner, mem_addr);
        end
    endtask

    task automatic test_z3_read();
        do_reset();
        z3_req = 1'b1; z3_addr = 26'h0123456; z3_rw = 1'b1; z3_ds_n = 4'b0000;
        step();
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 26'h0123456 || mem_rw !== 1'b1 || owner !== 2'd1) begin
            failures++;
            $display("FAIL z3_grant req=%b addr=%h rw=%b owner=%0d exp 1 0123456 1 1",
                     mem_req, mem_addr, mem_rw, owner);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (mem_req !== 1'b1 || mem_addr !== 26'h0123456 || z3_ack !== 1'b0) begin
                failures++;
                $display("FAIL z3_hold req=%b addr=%h ack=%b exp 1 0123456 0", mem_req, mem_addr, z3_ack);
            end
        end
        mem_done = 1'b1;
        step();
        checks++;
        if (z3_ack !== 1'b1 || mem_req !== 1'b0 || owner !== 2'd1) begin
            failures++;
            $display("FAIL z3_ack ack=%b req=%b owner=%0d exp 1 0 1", z3_ack, mem_req, owner);
        end
        mem_done = 1'b0;
        z3_req   = 1'b0;
        step();
        checks++;
        if (z3_ack !== 1'b0 || owner !== 2'd0 || mem_ds_n !== 4'b1111) begin
            failures++;
            $display("FAIL z3_release ack=%b owner=%0d ds_n=%b exp 0 0 1111", z3_ack, owner, mem_ds_n);
        end
    endtask

    task automatic test_same_cycle();
        do_reset();
        z3_req  = 1'b1; z3_addr  = 26'h0000ABC; z3_rw  = 1'b1; z3_ds_n  = 4'b0000;
        aux_req = 1'b1; aux_addr = 26'h3FF0001; aux_rw = 1'b0; aux_ds_n = 4'b1100;
        step();
        checks++;
        if (owner !== 2'd1 || mem_addr !== 26'h0000ABC) begin
            failures++;
            $display("FAIL tie_z3_first owner=%0d addr=%h exp 1 0000abc", owner, mem_addr);
        end
        mem_done = 1'b1;
        step();
        mem_done = 1'b0;
        z3_req   = 1'b0;
        step();
        checks++;
        if (owner !== 2'd0 || mem_req !== 1'b0) begin
            failures++;
            $display("FAIL tie_release owner=%0d req=%b exp 0 0", owner, mem_req);
        end
        step();
        checks++;
        if (owner !== 2'd2 || mem_req !== 1'b1 || mem_ds_n !== 4'b1100 ||
            mem_addr !== 26'h3FF0001 || mem_rw !== 1'b0) begin
            failures++;
            $display("FAIL tie_aux_grant owner=%0d req=%b ds_n=%b addr=%h rw=%b exp 2 1 1100 3ff0001 0",
                     owner, mem_req, mem_ds_n, mem_addr, mem_rw);
        end
        mem_done = 1'b1;
        step();
        checks++;
        if (aux_ack !== 1'b1 || z3_ack !== 1'b0) begin
            failures++;
            $display("FAIL tie_aux_ack aux_ack=%b z3_ack=%b exp 1 0", aux_ack, z3_ack);
        end
        mem_done = 1'b0;
        aux_req  = 1'b0;
        step();
        step();
    endtask

    task automatic test_stray_done();
        do_reset();
        mem_done = 1'b1;
        ref_done = 1'b1;
        step();
        mem_done = 1'b0;
        ref_done = 1'b0;
        step();
        checks++;
        if (owner !== 2'd0 || z3_ack !== 1'b0 || aux_ack !== 1'b0 || ref_req !== 1'b0 || mem_req !== 1'b0) begin
            failures++;
            $display("FAIL stray_done owner=%0d z3_ack=%b aux_ack=%b ref_req=%b mem_req=%b exp all 0",
                     owner, z3_ack, aux_ack, ref_req, mem_req);
        end
    endtask

    task automatic test_starvation();
        int z3_acks  = 0;
        int aux_acks = 0;
        do_reset();
        auto_mem = 1'b1;
        auto_ref = 1'b1;
        z3_req  = 1'b1; z3_addr  = 26'h0000010; z3_ds_n  = 4'b0000;
        aux_req = 1'b1; aux_addr = 26'h0000020; aux_ds_n = 4'b0011;
        for (int i = 0; i < 120; i++) begin
            step();
            if (z3_ack) begin
                z3_acks++;
                z3_req = 1'b0;
            end else begin
                z3_req = 1'b1;
            end
            if (aux_ack) begin
                aux_acks++;
                aux_req = 1'b0;
            end
        end
        z3_req  = 1'b0;
        aux_req = 1'b0;
        repeat (6) step();
        checks++;
        if (z3_acks < 5) begin
            failures++;
            $display("FAIL starve_z3_traffic got=%0d exp>=5", z3_acks);
        end
`ifdef SDRAM_ARB_STARVE_GUARD_EN
        checks++;
        if (aux_acks !== 1) begin
            failures++;
            $display("FAIL starve_guard_aux got=%0d exp=1", aux_acks);
        end
`else
        checks++;
        if (aux_acks !== 0) begin
            failures++;
            $display("FAIL starve_fixed_aux got=%0d exp=0", aux_acks);
        end
`endif
    endtask

    task automatic test_refresh_midgrant();
        int held_bad = 0;
        do_reset();
        repeat (26) step();
        z3_req = 1'b1; z3_addr = 26'h0000555; z3_ds_n = 4'b0000; z3_rw = 1'b0;
        step();
        checks++;
        if (owner !== 2'd1) begin
            failures++;
            $display("FAIL midgrant_grant owner=%0d exp=1", owner);
        end
        for (int i = 0; i < 9; i++) begin
            step();
            if (ref_req !== 1'b0 || owner !== 2'd1) held_bad++;
        end
        checks++;
        if (held_bad != 0) begin
            failures++;
            $display("FAIL midgrant_no_preempt bad_cycles=%0d exp=0", held_bad);
        end
        mem_done = 1'b1;
        step();
        mem_done = 1'b0;
        z3_req   = 1'b0;
        step();
        z3_req = 1'b1;
        step();
        checks++;
        if (ref_req !== 1'b1 || owner !== 2'd3 || mem_req !== 1'b0) begin
            failures++;
            $display("FAIL midgrant_refresh_first ref_req=%b owner=%0d mem_req=%b exp 1 3 0",
                     ref_req, owner, mem_req);
        end
        ref_done = 1'b1;
        step();
        ref_done = 1'b0;
        step();
        step();
        checks++;
        if (owner !== 2'd1 || mem_req !== 1'b1 || ref_req !== 1'b0) begin
            failures++;
            $display("FAIL midgrant_z3_after owner=%0d mem_req=%b ref_req=%b exp 1 1 0",
                     owner, mem_req, ref_req);
        end
        mem_done = 1'b1;
        step();
        mem_done = 1'b0;
        z3_req   = 1'b0;
        repeat (2) step();
    endtask

    task automatic test_periodic_refresh();
        int  nrise = 0;
        int  r0 = 0, r1 = 0, r2 = 0;
        logic prev = 1'b0;
        do_reset();
        auto_ref = 1'b1;
        for (int t = 1; t <= 4 * N; t++) begin
            step();
            if (ref_req && !prev) begin
                if (nrise == 0) r0 = t;
                else if (nrise == 1) r1 = t;
                else if (nrise == 2) r2 = t;
                nrise++;
            end
            prev = ref_req;
        end
        checks++;
        if (nrise < 3) begin
            failures++;
            $display("FAIL periodic_count got=%0d exp>=3", nrise);
        end
        checks++;
        if (r0 < N || r0 > N + 1) begin
            failures++;
            $display("FAIL periodic_first got=%0d exp=%0d..%0d", r0, N, N + 1);
        end
        checks++;
        if ((r1 - r0) != N || (r2 - r1) != N) begin
            failures++;
            $display("FAIL periodic_interval got=%0d,%0d exp=%0d", r1 - r0, r2 - r1, N);
        end
    endtask

    task automatic test_overrun();
        do_reset();
        repeat (4 * N - 1) step();
        checks++;
        if (ref_overrun !== 1'b0 || ref_req !== 1'b1) begin
            failures++;
            $display("FAIL overrun_early ovr=%b ref_req=%b exp 0 1", ref_overrun, ref_req);
        end
        step();
        checks++;
        if (ref_overrun !== 1'b1) begin
            failures++;
            $display("FAIL overrun_set got=%b exp=1", ref_overrun);
        end
        for (int i = 0; i < 3; i++) begin
            ref_done = 1'b1;
            step();
            ref_done = 1'b0;
            step();
            step();
            checks++;
            if (ref_req !== (i < 2)) begin
                failures++;
                $display("FAIL overrun_pend_drain iter=%0d ref_req=%b exp=%b", i, ref_req, (i < 2));
            end
        end
        checks++;
        if (ref_overrun !== 1'b1) begin
            failures++;
            $display("FAIL overrun_sticky got=%b exp=1", ref_overrun);
        end
        RESET = 1'b1;
        #1;
        checks++;
        if (ref_overrun !== 1'b0) begin
            failures++;
            $display("FAIL overrun_clear got=%b exp=0", ref_overrun);
        end
    endtask

    task automatic test_reset_midgrant();
        int t_ref = 0;
        do_reset();
        aux_req = 1'b1; aux_addr = 26'h2AAAAAA; aux_ds_n = 4'b1100; aux_rw = 1'b1;
        step();
        checks++;
        if (owner !== 2'd2 || mem_req !== 1'b1 || mem_ds_n !== 4'b1100) begin
            failures++;
            $display("FAIL rstmid_grant owner=%0d req=%b ds_n=%b exp 2 1 1100", owner, mem_req, mem_ds_n);
        end
        #2;
        RESET = 1'b1;
        #1;
        checks++;
        if (mem_req !== 1'b0 || aux_ack !== 1'b0 || owner !== 2'd0 || mem_ds_n !== 4'b1111) begin
            failures++;
            $display("FAIL rstmid_async req=%b ack=%b owner=%0d ds_n=%b exp 0 0 0 1111",
                     mem_req, aux_ack, owner, mem_ds_n);
        end
        aux_req = 1'b0;
        @(posedge CLK);
        #1;
        RESET    = 1'b0;
        auto_ref = 1'b1;
        for (int t = 1; t <= 2 * N; t++) begin
            step();
            if (ref_req && t_ref == 0) t_ref = t;
        end
        checks++;
        if (t_ref < N || t_ref > N + 1) begin
            failures++;
            $display("FAIL rstmid_first_ref got=%0d exp=%0d..%0d", t_ref, N, N + 1);
        end
    endtask

    initial begin
        z3_req = 1'b0; z3_rw = 1'b0; z3_addr = 26'd0; z3_ds_n = 4'b1111;
        aux_req = 1'b0; aux_rw = 1'b0; aux_addr = 26'd0; aux_ds_n = 4'b1111;
        mem_done = 1'b0; ref_done = 1'b0;
        test_reset();
        test_z3_read();
        test_same_cycle();
        test_stray_done();
        test_starvation();
        test_refresh_midgrant();
        test_periodic_refresh();
        test_overrun();
        test_reset_midgrant();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sdram_arbiter.md
Name: sdram_arbiter

Overview:
- Shares the single SDRAM controller between two requesters: the Zorro III slave path (z3) and an auxiliary local master (aux).
- Also schedules auto-refresh. It owns the refresh interval timer, so refresh is no longer paced by ECLK.
- Sits between the Zorro III cycle decoder / aux master and the SDRAM command sequencer.
- Presents one registered request (address, strobes, direction) downstream and routes completion back to the owner.

Parameters:
- REFRESH_CYCLES, 177: CLK cycles between refresh requests (about 7.1 us at 25 MHz).
- AUX_MAX_WAIT, 16: CLK cycles aux may wait before it overrides z3 priority.
- TMR_W, 8: width of the refresh timer; must hold REFRESH_CYCLES.

Ports:
- CLK  in  1  system clock; all logic on rising edge.
- RESET  in  1  asynchronous, active-high reset.
- z3_req  in  1  Zorro III port request; held until z3_ack.
- z3_addr  in  26  Zorro III address [27:2].
- z3_ds_n  in  4  Zorro III byte strobes, active low.
- z3_rw  in  1  Zorro III direction: 1 = read, 0 = write.
- z3_ack  out  1  one-cycle completion pulse to the Zorro III port.
- aux_req  in  1  aux port request; held until aux_ack.
- aux_addr  in  26  aux address [27:2].
- aux_ds_n  in  4  aux byte strobes, active low.
- aux_rw  in  1  aux direction: 1 = read, 0 = write.
- aux_ack  out  1  one-cycle completion pulse to the aux port.
- mem_req  out  1  access request to the SDRAM sequencer.
- mem_addr  out  26  registered address [27:2].
- mem_ds_n  out  4  registered byte strobes.
- mem_rw  out  1  registered direction.
- mem_done  in  1  sequencer pulse: access finished, precharge issued.
- ref_req  out  1  refresh request to the sequencer.
- ref_done  in  1  sequencer pulse: refresh finished (tRFC met).
- owner  out  2  current owner: 0 none, 1 z3, 2 aux, 3 refresh.
- ref_overrun  out  1  sticky flag; set when the pending-refresh counter saturates.

Behaviour:
- Reset values: every output is 0, except mem_ds_n = 4'b1111. State = IDLE; ref_pend = 0; the timer loads REFRESH_CYCLES-1; aux_wait = 0.
- Refresh timer: decrements every cycle. At 0 it reloads REFRESH_CYCLES-1 and increments ref_pend (2 bits, saturating at 3).
- ref_overrun: sets when an expiry arrives while ref_pend == 3. Only RESET clears it.
- ref_pend decrements on ref_done. If expiry and ref_done occur in the same cycle, ref_pend is unchanged.
- IDLE: arbitration, evaluated in this order:
  1. ref_pend != 0 -> REFRESH.
  2. aux_req && aux_wait >= AUX_MAX_WAIT -> GNT_AUX.
  3. z3_req -> GNT_Z3.
  4. aux_req -> GNT_AUX.
  5. Otherwise stay in IDLE.
- Grant entry: on the IDLE->GNT_* edge, capture the winner's addr/ds_n/rw into the mem_* outputs and set mem_req = 1 and owner. Grant latency is 1 cycle from request sampled to mem_req high.
- GNT_Z3 / GNT_AUX: hold mem_* stable and mem_req = 1 until mem_done. On mem_done:
  - mem_req <= 0;
  - the owner's ack <= 1 for exactly one cycle;
  - go to RELEASE.
- RELEASE: one cycle; owner <= 0; mem_ds_n <= 4'b1111; then IDLE. The requester must drop req on the edge where it samples ack, so it is never re-granted by a stale request. Back-to-back grants are therefore at least 3 cycles apart.
- REFRESH: ref_req = 1 and owner = 3 until ref_done, then ref_req <= 0 and go to RELEASE. Refresh never preempts an active grant; it waits for mem_done.
- aux_wait: increments (saturating) each cycle aux_req is high and aux does not own the port. It clears when aux is granted or aux_req is low.
- mem_done or ref_done outside the matching state is ignored; the state is unchanged and no ack is generated.
- Requests are sampled only in IDLE. Requests that drop during another owner's grant are simply lost; no latching.
- Reset mid-grant: all outputs return to reset values immediately and asynchronously. The pending refresh count is discarded and the sequencer must reinitialise.

Optional Feature:
- Macro: SDRAM_ARB_STARVE_GUARD_EN.
- Defined: the aux_wait counter and priority step 2 are present, as described above.
- Undefined: fixed priority refresh > z3 > aux. No aux_wait logic is synthesised, and AUX_MAX_WAIT is unused. aux can starve under continuous z3 traffic.

Decomposition:
- Package sdram_arb_pkg holds:
  - the state encoding (IDLE, GNT_Z3, GNT_AUX, REFRESH, RELEASE);
  - the owner codes (OWN_NONE=0, OWN_Z3=1, OWN_AUX=2, OWN_REF=3);
  - the default REFRESH_CYCLES.
- Sub-module sdram_refresh_timer contains the down-counter, the saturating ref_pend counter and ref_overrun. Inputs: CLK, RESET, ref_done. Outputs: ref_pend_nz, ref_overrun.

Test Plan:
- z3_req=1, read of addr 0x0123456: mem_req rises 1 cycle later with mem_addr=0x0123456 and mem_rw=1. mem_done at cycle 5 -> z3_ack pulse at cycle 6, owner returns to 0 at cycle 7.
- z3_req and aux_req asserted in the same cycle: z3 is granted first. After RELEASE, aux is granted with its captured ds_n (for example 4'b1100).
- Continuous z3 traffic with aux_req held and the guard macro defined: aux is granted at the first IDLE after 16 waiting cycles. With the macro undefined, aux is never granted.
- REFRESH_CYCLES=8 and idle ports: ref_req rises every 8 cycles. A refresh expiring mid-grant is held until after mem_done, then ref_req asserts before any pending z3_req is served.
- ref_done withheld across 4 expiries: ref_pend saturates at 3 and ref_overrun=1. It stays 1 after subsequent ref_done pulses and clears only on RESET.
- RESET asserted while in GNT_AUX with mem_req=1: mem_req, aux_ack and owner are 0 and mem_ds_n=4'b1111 in the same cycle. After release, the first ref_req arrives REFRESH_CYCLES cycles later.
